// File: rtl/collision_scheduler.sv
// Per-frame collision scanner: one shared wall/bird overlap comparator walks every wall slot and keeps the sticky game_over flag.
// Optional build macro COLLISION_FLOOR_CHECK_EN adds a floor/ceiling test to the end-of-scan verdict.
module collision_scheduler #(
  parameter int NUM_WALLS = 4,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int SCREEN_H  = 120,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             restart,
  input  logic [X_W-1:0]   bird_xleft,
  input  logic [X_W-1:0]   bird_xright,
  input  logic [Y_W-1:0]   bird_ytop,
  input  logic [Y_W-1:0]   bird_ybottom,
  output logic [IDX_W-1:0] wall_sel,
  input  logic             wall_active,
  input  logic [X_W-1:0]   wall_xleft,
  input  logic [X_W-1:0]   wall_xright,
  input  logic [Y_W-1:0]   wall_topy,
  input  logic [Y_W-1:0]   wall_bottomy,
  output logic             busy,
  output logic             scan_done,
  output logic             hit,
  output logic [IDX_W-1:0] hit_index,
  output logic             game_over
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WALLS - 1);

  generate
    if (NUM_WALLS < 1 || NUM_WALLS > 15 || (1 << IDX_W) <= NUM_WALLS || SCREEN_H < 2) begin : g_bad_cfg
      $error("collision_scheduler: illegal parameter combination");
    end
  endgenerate

  logic [2:0]       state_q,     state_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [X_W-1:0]   snap_xl_q,   snap_xl_d;
  logic [X_W-1:0]   snap_xr_q,   snap_xr_d;
  logic [Y_W-1:0]   snap_yt_q,   snap_yt_d;
  logic [Y_W-1:0]   snap_yb_q,   snap_yb_d;
  logic             acc_hit_q,   acc_hit_d;
  logic [IDX_W-1:0] acc_idx_q,   acc_idx_d;
  logic             hit_q,       hit_d;
  logic [IDX_W-1:0] hit_index_q, hit_index_d;
  logic             game_over_q, game_over_d;

  logic             in_x;
  logic             out_gap;
  logic             slot_hit;
  logic             floor_hit;
  logic             scan_hit;
  logic [IDX_W-1:0] scan_idx;

  assign in_x     = (snap_xr_q >= wall_xleft) && (snap_xl_q <= wall_xright);
  assign out_gap  = (snap_yt_q <= wall_topy) || (snap_yb_q >= wall_bottomy);
  assign slot_hit = wall_active && in_x && out_gap;

`ifdef COLLISION_FLOOR_CHECK_EN
  localparam logic [Y_W-1:0]   FLOOR_Y   = Y_W'(SCREEN_H - 1);
  localparam logic [IDX_W-1:0] FLOOR_IDX = IDX_W'(NUM_WALLS);

  assign floor_hit = (snap_yt_q == '0) || (snap_yb_q >= FLOOR_Y);

  // A wall hit always owns hit_index; the floor code only shows when no wall collided.
  always_comb begin
    if (acc_hit_q)      scan_idx = acc_idx_q;
    else if (slot_hit)  scan_idx = idx_q;
    else if (floor_hit) scan_idx = FLOOR_IDX;
    else                scan_idx = '0;
  end
`else
  assign floor_hit = 1'b0;

  always_comb begin
    if (acc_hit_q)     scan_idx = acc_idx_q;
    else if (slot_hit) scan_idx = idx_q;
    else               scan_idx = '0;
  end
`endif

  // Verdict for the scan, folding in the slot being checked on the final CHECK cycle.
  assign scan_hit = acc_hit_q || slot_hit || floor_hit;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_xl_d   = snap_xl_q;
    snap_xr_d   = snap_xr_q;
    snap_yt_d   = snap_yt_q;
    snap_yb_d   = snap_yb_q;
    acc_hit_d   = acc_hit_q;
    acc_idx_d   = acc_idx_q;
    hit_d       = hit_q;
    hit_index_d = hit_index_q;
    game_over_d = game_over_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          snap_xl_d = bird_xleft;
          snap_xr_d = bird_xright;
          snap_yt_d = bird_ytop;
          snap_yb_d = bird_ybottom;
          acc_hit_d = 1'b0;
          acc_idx_d = '0;
          idx_d     = '0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (slot_hit && !acc_hit_q) begin
          acc_hit_d = 1'b1;
          acc_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          hit_d       = scan_hit;
          hit_index_d = scan_idx;
          state_d     = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (hit_q) begin
          game_over_d = 1'b1;
          state_d     = ST_OVER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Restart overrides any scan in flight and any tick arriving in the same cycle.
    if (restart) begin
      state_d     = ST_IDLE;
      game_over_d = 1'b0;
      hit_d       = 1'b0;
      hit_index_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      snap_xl_q   <= '0;
      snap_xr_q   <= '0;
      snap_yt_q   <= '0;
      snap_yb_q   <= '0;
      acc_hit_q   <= 1'b0;
      acc_idx_q   <= '0;
      hit_q       <= 1'b0;
      hit_index_q <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_xl_q   <= snap_xl_d;
      snap_xr_q   <= snap_xr_d;
      snap_yt_q   <= snap_yt_d;
      snap_yb_q   <= snap_yb_d;
      acc_hit_q   <= acc_hit_d;
      acc_idx_q   <= acc_idx_d;
      hit_q       <= hit_d;
      hit_index_q <= hit_index_d;
      game_over_q <= game_over_d;
    end
  end

  assign wall_sel  = idx_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_CHECK) || (state_q == ST_DONE);
  assign scan_done = (state_q == ST_DONE);
  assign hit       = hit_q;
  assign hit_index = hit_index_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler: scan-level reference model checked every cycle, plus directed scenarios with literal results.
module tb_collision_scheduler;
  localparam int NW = 4;

  logic       clk = 1'b0;
  logic       reset, frame_tick, restart;
  logic [8:0] bird_xleft, bird_xright;
  logic [7:0] bird_ytop, bird_ybottom;
  logic [3:0] wall_sel;
  logic       wall_active;
  logic [8:0] wall_xleft, wall_xright;
  logic [7:0] wall_topy, wall_bottomy;
  logic       busy, scan_done, hit, game_over;
  logic [3:0] hit_index;

  collision_scheduler #(.NUM_WALLS(NW), .X_W(9), .Y_W(8), .SCREEN_H(120), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .restart(restart),
    .bird_xleft(bird_xleft), .bird_xright(bird_xright),
    .bird_ytop(bird_ytop), .bird_ybottom(bird_ybottom),
    .wall_sel(wall_sel), .wall_active(wall_active),
    .wall_xleft(wall_xleft), .wall_xright(wall_xright),
    .wall_topy(wall_topy), .wall_bottomy(wall_bottomy),
    .busy(busy), .scan_done(scan_done), .hit(hit),
    .hit_index(hit_index), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Wall register file with one cycle of read latency.
  logic       w_act [16];
  logic [8:0] w_xl  [16];
  logic [8:0] w_xr  [16];
  logic [7:0] w_ty  [16];
  logic [7:0] w_by  [16];

  always @(posedge clk) begin
    wall_active  <= w_act[wall_sel];
    wall_xleft   <= w_xl[wall_sel];
    wall_xright  <= w_xr[wall_sel];
    wall_topy    <= w_ty[wall_sel];
    wall_bottomy <= w_by[wall_sel];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // Whole-scan verdict straight from the overlap rules.
  function automatic void judge(input logic [8:0] bxl, input logic [8:0] bxr,
                                input logic [7:0] byt, input logic [7:0] byb,
                                output bit h, output int idx);
    h = 0;
    idx = 0;
    for (int i = 0; i < NW; i++) begin
      if (!h && w_act[i] && bxr >= w_xl[i] && bxl <= w_xr[i] &&
          (byt <= w_ty[i] || byb >= w_by[i])) begin
        h = 1;
        idx = i;
      end
    end
`ifdef COLLISION_FLOOR_CHECK_EN
    if (!h && (byt == 0 || byb >= 119)) begin
      h = 1;
      idx = NW;
    end
`endif
  endfunction

  // Model: m_cnt counts cycles left in the scan; scan_done is due when it reads 1.
  bit m_valid = 0;
  int m_cnt = 0;
  bit m_hit = 0, m_go = 0, p_hit = 0;
  int m_idx = 0, p_idx = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1;
      m_cnt = 0; m_hit = 0; m_idx = 0; m_go = 0;
    end else if (restart) begin
      m_cnt = 0; m_hit = 0; m_idx = 0; m_go = 0;
    end else begin
      if (m_cnt == 2) begin
        m_hit = p_hit;
        m_idx = p_idx;
      end
      if (m_cnt == 1 && p_hit) m_go = 1;
      if (m_cnt > 0) m_cnt--;
      else if (frame_tick && !m_go) begin
        judge(bird_xleft, bird_xright, bird_ytop, bird_ybottom, p_hit, p_idx);
        m_cnt = 2 * NW + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("scan_done", scan_done, m_cnt == 1);
      check("busy", busy, m_cnt > 0);
      check("hit", hit, m_hit);
      check("hit_index", hit_index, m_idx);
      check("game_over", game_over, m_go);
      if (m_cnt >= 2) check("wall_sel", wall_sel, (2 * NW + 1 - m_cnt) / 2);
    end
  end

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  // Tick, then wait (bounded) for scan_done; leaves the bench on the DONE cycle.
  task automatic run_scan(output int lat);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    lat = 1;
    while (!scan_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_done(input int cycles, output int n, output logic h);
    n = 0;
    h = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (scan_done) begin
        n++;
        h = hit;
      end
      @(negedge clk);
    end
  endtask

  task automatic clear_walls();
    for (int i = 0; i < 16; i++) begin
      w_act[i] = 1'b0; w_xl[i] = '0; w_xr[i] = '0; w_ty[i] = '0; w_by[i] = '0;
    end
  endtask

  task automatic set_wall(input int s, input int xl, input int xr, input int ty, input int by);
    w_act[s] = 1'b1;
    w_xl[s] = 9'(xl); w_xr[s] = 9'(xr); w_ty[s] = 8'(ty); w_by[s] = 8'(by);
  endtask

  task automatic set_bird(input int xl, input int xr, input int yt, input int yb);
    bird_xleft = 9'(xl); bird_xright = 9'(xr); bird_ytop = 8'(yt); bird_ybottom = 8'(yb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, n;
    logic h;
    reset = 1'b1; frame_tick = 1'b0; restart = 1'b0;
    clear_walls();
    set_bird(40, 47, 50, 57);
    repeat (3) @(negedge clk);
    check("reset_wall_sel", wall_sel, 0);
    check("reset_game_over", game_over, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: no live walls, latency 2*NW+1
    run_scan(lat);
    check("s1_latency", lat, 9);
    check("s1_hit", hit, 0);
    @(negedge clk);
    check("s1_idle", busy, 0);

    // 2: slot 2 collides below the gap
    set_wall(2, 44, 60, 30, 55);
    run_scan(lat);
    check("s2_latency", lat, 9);
    check("s2_hit", hit, 1);
    check("s2_hit_index", hit_index, 2);
    @(negedge clk);
    check("s2_game_over", game_over, 1);
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    count_done(12, n, h);
    check("s2_over_no_scan", n, 0);
    check("s2_over_hold_idx", hit_index, 2);

    // 3: inclusive edge touch on slot 1 beats the later hit on slot 3
    pulse_restart();
    check("s3_restart_go", game_over, 0);
    set_wall(2, 44, 60, 40, 70);
    set_wall(1, 47, 60, 50, 70);
    set_wall(3, 40, 41, 60, 90);
    run_scan(lat);
    check("s3_hit", hit, 1);
    check("s3_hit_index", hit_index, 1);
    @(negedge clk);

    // 4: snapshot used, second tick dropped
    pulse_restart();
    clear_walls();
    set_wall(0, 100, 110, 30, 55);
    set_bird(40, 47, 50, 57);
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    set_bird(100, 107, 50, 57);
    @(negedge clk);
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    count_done(14, n, h);
    check("s4_one_scan", n, 1);
    check("s4_snapshot_hit", h, 0);
    check("s4_game_over", game_over, 0);

    // 5: restart mid-scan after a game over
    run_scan(lat);
    check("s5_first_hit_index", hit_index, 0);
    check("s5_first_hit", hit, 1);
    @(negedge clk);
    check("s5_game_over", game_over, 1);
    pulse_restart();
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    pulse_restart();
    check("s5_abort_go", game_over, 0);
    check("s5_abort_hit", hit, 0);
    count_done(12, n, h);
    check("s5_abort_no_done", n, 0);
    set_bird(40, 47, 50, 57);
    run_scan(lat);
    check("s5_rescan_latency", lat, 9);
    check("s5_rescan_hit", hit, 0);
    @(negedge clk);

    // 6: bird on the floor, no live walls
    clear_walls();
    set_bird(40, 47, 112, 119);
    run_scan(lat);
`ifdef COLLISION_FLOOR_CHECK_EN
    check("s6_floor_hit", hit, 1);
    check("s6_floor_index", hit_index, 4);
    @(negedge clk);
    check("s6_floor_go", game_over, 1);
`else
    check("s6_floor_hit", hit, 0);
    @(negedge clk);
    check("s6_floor_go", game_over, 0);
`endif
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Per-frame sequencer that time-shares one wall-vs-bird overlap comparator across NUM_WALLS wall slots.
- On each frame tick it snapshots the bird box, walks the wall register file one slot at a time and reports the first colliding wall.
- It owns the sticky game_over flag consumed by the game FSM and the VGA draw logic.

Parameters:
NUM_WALLS, 4, number of wall slots scanned per frame (1..15)
X_W, 9, width of x coordinates
Y_W, 8, width of y coordinates
SCREEN_H, 120, playfield height in pixels; used only by the floor/ceiling check
IDX_W, 4, width of wall_sel/hit_index; must satisfy 2^IDX_W > NUM_WALLS

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse: start a scan
restart  in  1  one-cycle pulse: clear game_over, return to IDLE
bird_xleft  in  X_W  bird box left edge
bird_xright  in  X_W  bird box right edge
bird_ytop  in  Y_W  bird box top edge
bird_ybottom  in  Y_W  bird box bottom edge
wall_sel  out  IDX_W  wall slot address to the wall register file
wall_active  in  1  selected slot holds a live wall (valid 1 cycle after wall_sel)
wall_xleft  in  X_W  selected wall left edge (valid 1 cycle after wall_sel)
wall_xright  in  X_W  selected wall right edge
wall_topy  in  Y_W  bottom edge of the upper pipe (top of gap)
wall_bottomy  in  Y_W  top edge of the lower pipe (bottom of gap)
busy  out  1  scan in progress
scan_done  out  1  one-cycle pulse at end of each scan
hit  out  1  result of last completed scan
hit_index  out  IDX_W  lowest colliding slot of last scan; NUM_WALLS = floor/ceiling
game_over  out  1  sticky collision flag

Behaviour:
- Reset (sync, active-high, priority over everything): state IDLE; wall_sel=0, busy=0, scan_done=0, hit=0, hit_index=0, game_over=0, snapshot regs=0.
- States: IDLE, FETCH, CHECK, DONE, OVER.
- IDLE: frame_tick=1 -> latch all four bird coords into snapshot regs, clear scan-hit accumulator, idx=0, go FETCH. busy=0 only in IDLE and OVER.
- FETCH: drive wall_sel=idx; go CHECK (one-cycle wall register file read latency).
- CHECK: evaluate slot idx against the snapshot. All compares unsigned and inclusive:
  - in_x = snap_xright >= wall_xleft AND snap_xleft <= wall_xright
  - out_gap = snap_ytop <= wall_topy OR snap_ybottom >= wall_bottomy
  - slot_hit = wall_active AND in_x AND out_gap
  - First slot_hit in the scan records idx into the hit_index accumulator; later hits do not overwrite it.
  - idx == NUM_WALLS-1 -> go DONE; otherwise idx+1 and go FETCH.
- DONE: scan_done=1 for exactly this cycle; hit/hit_index updated from the accumulator in this cycle. If accumulator hit: game_over<=1, go OVER; else go IDLE.
- Latency: frame_tick sampled at cycle T -> scan_done high at T+2*NUM_WALLS+1.
- OVER: frame_tick ignored; game_over, hit and hit_index hold.
- frame_tick while busy (FETCH/CHECK/DONE): ignored, not queued.
- Bird inputs changing mid-scan: no effect; only the snapshot is used.
- wall_sel holds its last value outside FETCH/CHECK.
- restart (any state except under reset): next state IDLE; game_over, hit, hit_index cleared; any scan in flight is aborted with no scan_done. restart and frame_tick in the same cycle: restart wins, the tick is dropped.
- Widths: idx counter is IDX_W bits and never exceeds NUM_WALLS-1.

Optional Feature:
- Macro: COLLISION_FLOOR_CHECK_EN
- Defined: DONE additionally flags a hit if snap_ytop == 0 or snap_ybottom >= SCREEN_H-1. A floor/ceiling hit sets hit=1 and game_over=1. If no wall collided, hit_index=NUM_WALLS; a wall hit always takes precedence for hit_index. No extra cycle is added.
- Undefined: no floor/ceiling compare is generated; the bird may leave the screen without a hit.

Test Plan:
- Reset, then frame_tick; all slots wall_active=0 -> scan_done at T+9 (NUM_WALLS=4), hit=0, game_over=0, back in IDLE.
- Bird x 40..47, y 50..57; slot 2 live, x 44..60, gap topy=30 / bottomy=55 -> hit=1, hit_index=2, game_over=1, state OVER; further frame_ticks produce no scan_done.
- Same bird, slot 2 gap topy=40 / bottomy=70 (bird inside gap); edge touch slot 1 x 47..60 with gap topy=50 -> hit_index=1 (inclusive compare, lowest index wins over any later hit).
- frame_tick at T, second frame_tick at T+3, bird coords changed at T+2 -> exactly one scan_done at T+9; result uses coords latched at T.
- restart pulsed at T+4 mid-scan after a prior game_over -> no scan_done, game_over=0, hit=0 next cycle; next frame_tick scans normally.
- With COLLISION_FLOOR_CHECK_EN defined, no live walls, bird ybottom=119 (SCREEN_H=120) -> hit=1, hit_index=4, game_over=1. Without the macro, the same stimulus gives hit=0.
